n_to_a: RTL and testbench

N_TO_A -- requirements
Module: n_to_a

---
 rtl/n_to_a.sv | 70 +++++++
 tb/tb_n_to_a.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/n_to_a.sv
// n_to_a: wide-word to byte serializer.
// Accepts an NBYTES*BW-bit word from upstream and emits it one BW-bit byte
// at a time, byte 0 first. A new word can be taken in the same cycle the last
// byte of the current word leaves, so back-to-back words stream without gaps.
// Optional feature macro: NTOA_LAST_EN adds io_a_last, high with the final
// byte of each word.
module n_to_a #(
  parameter int NBYTES = 9,
  parameter int BW     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_n_valid,
  output logic                 io_n_ready,
  input  logic [NBYTES*BW-1:0] io_n_bits,
  output logic                 io_a_valid,
  input  logic                 io_a_ready,
  output logic [BW-1:0]        io_a_bits
`ifdef NTOA_LAST_EN
  ,
  output logic                 io_a_last
`endif
);

  localparam int W  = NBYTES * BW;
  localparam int CW = $clog2(NBYTES + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(NBYTES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Word being drained; byte on offer always sits in the low BW bits.
  logic [W-1:0]  sr;
  // Bytes of the current word still to be handed downstream.
  logic [CW-1:0] cnt;

  logic n_fire;
  logic a_fire;

  // Handshake and output decode, all from registered state except the
  // io_a_ready term that lets a new word overlap the last byte.
  assign io_a_valid = (cnt != '0);
  assign io_a_bits  = sr[BW-1:0];
  assign io_n_ready = ~reset & ((cnt == '0) | ((cnt == CNT_ONE) & io_a_ready));

  assign n_fire = io_n_valid & io_n_ready;
  assign a_fire = io_a_valid & io_a_ready;

`ifdef NTOA_LAST_EN
  // Final byte of the word is the one offered when exactly one remains.
  assign io_a_last = (cnt == CNT_ONE);
`endif

  // Load a new word, or shift out one byte per downstream accept.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from
    // pre-edge values, so the order of statements here cannot matter.
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (n_fire) begin
      // A new word wins over the simultaneous departure of the last byte.
      sr  <= io_n_bits;
      cnt <= CNT_FULL;
    end else if (a_fire) begin
      sr  <= {{BW{1'b0}}, sr[W-1:BW]};
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_n_to_a.sv
// tb_n_to_a: self-checking bench for n_to_a.
// A queue of pending bytes models the serializer; a negedge process compares
// every output against it each cycle. Directed scenarios pin the model with
// hand-derived expectations, then a randomized phase exercises handshakes
// and reset.
module tb_n_to_a;

  localparam int NBYTES = 9;
  localparam int BW     = 8;
  localparam int W      = NBYTES * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          io_n_valid = 1'b0;
  logic          io_n_ready;
  logic [W-1:0]  io_n_bits = '0;
  logic          io_a_valid;
  logic          io_a_ready = 1'b0;
  logic [BW-1:0] io_a_bits;
`ifdef NTOA_LAST_EN
  logic          io_a_last;
`endif

  n_to_a #(.NBYTES(NBYTES), .BW(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_n_valid(io_n_valid),
    .io_n_ready(io_n_ready),
    .io_n_bits (io_n_bits),
    .io_a_valid(io_a_valid),
    .io_a_ready(io_a_ready),
    .io_a_bits (io_a_bits)
`ifdef NTOA_LAST_EN
    ,
    .io_a_last (io_a_last)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: bytes still owed downstream, oldest first.
  logic [BW-1:0] byte_q[$];

  // Observation logs used by the directed checks.
  logic [BW-1:0] cap_bytes[$];
  int            cap_cycles[$];
  int            acc_cycles[$];
  bit            nr_log[int];

  // Compare outputs against the model, log events, then advance the model.
  always @(negedge clk) begin
    bit            exp_valid;
    bit            exp_nready;
    logic [BW-1:0] exp_bits;
    exp_valid  = (byte_q.size() != 0);
    exp_bits   = exp_valid ? byte_q[0] : '0;
    exp_nready = !reset && (byte_q.size() == 0 || (byte_q.size() == 1 && io_a_ready));
    if (!reset) begin
      check("a_valid", 32'(io_a_valid), 32'(exp_valid));
      check("a_bits", 32'(io_a_bits), 32'(exp_bits));
`ifdef NTOA_LAST_EN
      check("a_last", 32'(io_a_last), 32'(byte_q.size() == 1));
`endif
    end
    check("n_ready", 32'(io_n_ready), 32'(exp_nready));

    if (io_a_valid && io_a_ready && !reset) begin
      cap_bytes.push_back(io_a_bits);
      cap_cycles.push_back(cycle);
    end
    nr_log[cycle] = io_n_ready;
    if (exp_nready && io_n_valid) acc_cycles.push_back(cycle);

    if (reset) begin
      byte_q.delete();
    end else if (exp_nready && io_n_valid) begin
      byte_q.delete();
      for (int i = 0; i < NBYTES; i++) byte_q.push_back(io_n_bits[i*BW +: BW]);
    end else if (exp_valid && io_a_ready) begin
      void'(byte_q.pop_front());
    end
    cycle++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cap_bytes.delete();
    cap_cycles.delete();
    acc_cycles.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    io_n_valid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < NBYTES; i++) w[i*BW +: BW] = BW'($urandom);
    return w;
  endfunction

  initial begin
    logic [W-1:0] word1;
    logic [W-1:0] word2;
    int           acc;
    int           guard;

    // Reset state.
    tick();
    check("reset_n_ready", 32'(io_n_ready), 32'd0);
    check("reset_a_valid", 32'(io_a_valid), 32'd0);
    check("reset_a_bits", 32'(io_a_bits), 32'd0);
    do_reset(2);
    @(negedge clk);
    check("post_reset_n_ready", 32'(io_n_ready), 32'd1);

    // Single word 01..09 with continuous downstream ready.
    tick();
    clear_logs();
    word1 = 72'h090807060504030201;
    io_n_bits  = word1;
    io_n_valid = 1'b1;
    io_a_ready = 1'b1;
    tick();
    io_n_valid = 1'b0;
    repeat (12) tick();
    check("w1_accepts", 32'(acc_cycles.size()), 32'd1);
    check("w1_bytes", 32'(cap_bytes.size()), 32'd9);
    if (acc_cycles.size() == 1 && cap_bytes.size() == 9) begin
      acc = acc_cycles[0];
      for (int k = 0; k < 9; k++) begin
        check("w1_byte_val", 32'(cap_bytes[k]), 32'(k + 1));
        check("w1_byte_cycle", 32'(cap_cycles[k]), 32'(acc + 1 + k));
        check("w1_n_ready_drain", 32'(nr_log[acc + 1 + k]), (k < 8) ? 32'd0 : 32'd1);
      end
    end

    // Two words back to back: 18 bytes, no bubble.
    clear_logs();
    word2 = rand_word();
    io_n_bits  = word1;
    io_n_valid = 1'b1;
    tick();
    io_n_bits = word2;
    guard = 0;
    while (acc_cycles.size() < 2 && guard < 20) begin
      tick();
      guard++;
    end
    check("w2_accept_timeout", 32'(acc_cycles.size() >= 2), 32'd1);
    io_n_valid = 1'b0;
    repeat (12) tick();
    check("w2_bytes", 32'(cap_bytes.size()), 32'd18);
    if (cap_bytes.size() == 18 && acc_cycles.size() == 2) begin
      check("w2_accept_at_byte9", 32'(acc_cycles[1]), 32'(cap_cycles[8]));
      for (int k = 0; k < 18; k++) begin
        check("w2_no_bubble", 32'(cap_cycles[k]), 32'(cap_cycles[0] + k));
        check("w2_byte_val", 32'(cap_bytes[k]),
              (k < 9) ? 32'(k + 1) : 32'(word2[(k-9)*BW +: BW]));
      end
    end

    // Downstream ready pattern 1,0,0 during a drain.
    clear_logs();
    io_a_ready = 1'b1;
    io_n_bits  = word1;
    io_n_valid = 1'b1;
    tick();
    io_n_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      io_a_ready = (k % 3 == 0);
      tick();
    end
    check("stall_bytes", 32'(cap_bytes.size()), 32'd9);
    if (cap_bytes.size() == 9)
      for (int k = 0; k < 9; k++) check("stall_byte_val", 32'(cap_bytes[k]), 32'(k + 1));

    // Reset after the 4th byte fires discards the rest of the word.
    clear_logs();
    io_a_ready = 1'b1;
    io_n_bits  = word1;
    io_n_valid = 1'b1;
    tick();
    io_n_valid = 1'b0;
    guard = 0;
    while (cap_bytes.size() < 4 && guard < 20) begin
      tick();
      guard++;
    end
    check("mid_reset_timeout", 32'(cap_bytes.size() >= 4), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_n_ready", 32'(io_n_ready), 32'd0);
    tick();
    @(negedge clk);
    check("mid_reset_a_valid", 32'(io_a_valid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_resume_n_ready", 32'(io_n_ready), 32'd1);
    check("mid_reset_idle", 32'(io_a_valid), 32'd0);
    tick();
    clear_logs();
    io_n_bits  = word1;
    io_n_valid = 1'b1;
    tick();
    io_n_valid = 1'b0;
    repeat (12) tick();
    check("post_reset_word_bytes", 32'(cap_bytes.size()), 32'd9);
    if (cap_bytes.size() == 9) check("post_reset_first_byte", 32'(cap_bytes[0]), 32'h01);

    // Randomized handshakes and occasional reset against the model.
    for (int k = 0; k < 3000; k++) begin
      io_n_valid = ($urandom_range(0, 1) == 1);
      io_n_bits  = rand_word();
      io_a_ready = ($urandom_range(0, 9) < 7);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset      = 1'b0;
    io_n_valid = 1'b0;
    io_a_ready = 1'b1;
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
